// File: rtl/vadd_launcher_pkg.sv
// Shared types and constants for the VecAdd launcher.
//   state_t        : launcher sequencing states
//   axil_wr_req_t  : single AXI-Lite write request (address + data)
//   ADDR_* / CTRL_START / DONE_BIT : VecAdd s_axi_control register map
//   ERR_*          : response error codes
package vadd_launcher_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR_NLO,
        WR_NHI,
        WR_START,
        POLL_AR,
        POLL_R,
        POLL_WAIT,
        RESP
    } state_t;

    localparam logic [4:0]  ADDR_CTRL  = 5'h00;
    localparam logic [4:0]  ADDR_N_LO  = 5'h10;
    localparam logic [4:0]  ADDR_N_HI  = 5'h14;
    localparam logic [31:0] CTRL_START = 32'h1;
    localparam int unsigned DONE_BIT   = 1;

    localparam logic [1:0] ERR_OK      = 2'd0;
    localparam logic [1:0] ERR_AXI     = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } axil_wr_req_t;

endpackage

// File: rtl/vadd_launcher_wr.sv
// One AXI-Lite write transaction (AW + W + B) per start pulse.
//   clk, rst_n          : clock, async active-low reset
//   start, req          : launch a write of req.data to req.addr
//   awvalid/awready/awaddr, wvalid/wready/wdata/wstrb : address and data channels
//   bvalid/bready/bresp : write response channel
//   done_c, resp_c      : B handshake this cycle, and its response code
// AW and W complete independently (their VALID drops on its own handshake);
// BREADY is only raised once both are complete, so B can never be taken early.
module axil_wr_single
    import vadd_launcher_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  axil_wr_req_t req,
    output logic         awvalid,
    input  logic         awready,
    output logic [4:0]   awaddr,
    output logic         wvalid,
    input  logic         wready,
    output logic [31:0]  wdata,
    output logic [3:0]   wstrb,
    input  logic         bvalid,
    output logic         bready,
    input  logic [1:0]   bresp,
    output logic         done_c,
    output logic [1:0]   resp_c
);

    logic aw_hs_c;
    logic w_hs_c;
    logic aw_fin_c;
    logic w_fin_c;

    assign aw_hs_c  = awvalid && awready;
    assign w_hs_c   = wvalid && wready;
    // Channel finished: either already done earlier or handshaking now.
    assign aw_fin_c = aw_hs_c || !awvalid;
    assign w_fin_c  = w_hs_c || !wvalid;
    assign done_c   = bvalid && bready;
    assign resp_c   = bresp;
    assign wstrb    = 4'hF;

    // Channel sequencing for the single outstanding write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            awvalid <= 1'b0;
            wvalid  <= 1'b0;
            bready  <= 1'b0;
            awaddr  <= '0;
            wdata   <= '0;
        end else if (start) begin
            awvalid <= 1'b1;
            wvalid  <= 1'b1;
            bready  <= 1'b0;
            awaddr  <= req.addr;
            wdata   <= req.data;
        end else begin
            if (aw_hs_c) awvalid <= 1'b0;
            if (w_hs_c)  wvalid  <= 1'b0;
            if ((awvalid || wvalid) && aw_fin_c && w_fin_c) bready <= 1'b1;
            if (done_c) bready <= 1'b0;
        end
    end

endmodule

// File: rtl/vadd_launcher.sv
// Command-driven AXI-Lite master running one VecAdd kernel per command:
// writes n (lo, hi), writes ap_start, polls ap_done, returns status + latency.
//   ap_clk, ap_rst_n          : clock, async active-low reset
//   cmd_valid/cmd_ready/cmd_n : command in (64-bit element count)
//   rsp_valid/rsp_ready       : response out
//   rsp_err                   : 0 ok, 1 AXI error, 2 poll timeout
//   rsp_cycles                : poll-phase cycles, start B handshake to done R handshake
//   busy                      : high outside IDLE
//   m_axi_control_*           : AXI-Lite master to the VecAdd control slave
// Optional: define VADD_LAUNCHER_TIMEOUT_EN to bound polling by TIMEOUT_CYC cycles.
module vadd_launcher
    import vadd_launcher_pkg::*;
#(
    parameter int unsigned POLL_GAP    = 4,
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned TIMEOUT_CYC = 1000000
) (
    input  logic             ap_clk,
    input  logic             ap_rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [63:0]      cmd_n,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [1:0]       rsp_err,
    output logic [CNT_W-1:0] rsp_cycles,
    output logic             busy,
    output logic             m_axi_control_AWVALID,
    input  logic             m_axi_control_AWREADY,
    output logic [4:0]       m_axi_control_AWADDR,
    output logic             m_axi_control_WVALID,
    input  logic             m_axi_control_WREADY,
    output logic [31:0]      m_axi_control_WDATA,
    output logic [3:0]       m_axi_control_WSTRB,
    input  logic             m_axi_control_BVALID,
    output logic             m_axi_control_BREADY,
    input  logic [1:0]       m_axi_control_BRESP,
    output logic             m_axi_control_ARVALID,
    input  logic             m_axi_control_ARREADY,
    output logic [4:0]       m_axi_control_ARADDR,
    input  logic             m_axi_control_RVALID,
    output logic             m_axi_control_RREADY,
    input  logic [31:0]      m_axi_control_RDATA,
    input  logic [1:0]       m_axi_control_RRESP
);

    localparam int unsigned GAP_W = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;

    state_t           state;
    logic [31:0]      n_hi_q;
    logic [CNT_W-1:0] cyc_cnt;
    logic [CNT_W-1:0] cyc_nxt_c;
    logic [GAP_W-1:0] gap_cnt;
    logic             gap_end_c;
    logic             in_poll_c;
    logic             wr_start_c;
    axil_wr_req_t     wr_req_c;
    logic             wr_done_c;
    logic [1:0]       wr_resp_c;
    logic             ar_hs_c;
    logic             r_hs_c;
    logic             to_hit_c;
    logic             unused_rdata;

    assign m_axi_control_ARADDR = ADDR_CTRL;
    assign ar_hs_c   = m_axi_control_ARVALID && m_axi_control_ARREADY;
    assign r_hs_c    = m_axi_control_RVALID && m_axi_control_RREADY;
    assign in_poll_c = (state == POLL_AR) || (state == POLL_R) || (state == POLL_WAIT);
    assign cyc_nxt_c = (&cyc_cnt) ? cyc_cnt : cyc_cnt + CNT_W'(1);
    // POLL_WAIT always lasts at least one cycle, so a gap of 0 behaves like 1.
    assign gap_end_c = (32'(gap_cnt) + 32'd1 >= POLL_GAP);
    assign unused_rdata = ^{m_axi_control_RDATA[31:DONE_BIT+1], m_axi_control_RDATA[DONE_BIT-1:0]};

`ifdef VADD_LAUNCHER_TIMEOUT_EN
    logic [31:0] to_cnt;

    // Poll-phase cycle count for the timeout, saturating.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            to_cnt <= '0;
        end else if (state == WR_START && wr_done_c) begin
            to_cnt <= '0;
        end else if (in_poll_c && !(&to_cnt)) begin
            to_cnt <= to_cnt + 32'd1;
        end
    end

    assign to_hit_c = (to_cnt >= 32'(TIMEOUT_CYC));
`else
    logic unused_timeout_cyc;

    assign to_hit_c           = 1'b0;
    assign unused_timeout_cyc = ^32'(TIMEOUT_CYC);
`endif

    // Next write request: issued on the edge that enters the write state.
    always_comb begin
        wr_start_c = 1'b0;
        wr_req_c   = '{addr: ADDR_N_LO, data: cmd_n[31:0]};
        case (state)
            IDLE: wr_start_c = cmd_valid && cmd_ready;
            WR_NLO: if (wr_done_c && wr_resp_c == 2'b00) begin
                wr_start_c = 1'b1;
                wr_req_c   = '{addr: ADDR_N_HI, data: n_hi_q};
            end
            WR_NHI: if (wr_done_c && wr_resp_c == 2'b00) begin
                wr_start_c = 1'b1;
                wr_req_c   = '{addr: ADDR_CTRL, data: CTRL_START};
            end
            default: ;
        endcase
    end

    axil_wr_single u_wr (
        .clk     (ap_clk),
        .rst_n   (ap_rst_n),
        .start   (wr_start_c),
        .req     (wr_req_c),
        .awvalid (m_axi_control_AWVALID),
        .awready (m_axi_control_AWREADY),
        .awaddr  (m_axi_control_AWADDR),
        .wvalid  (m_axi_control_WVALID),
        .wready  (m_axi_control_WREADY),
        .wdata   (m_axi_control_WDATA),
        .wstrb   (m_axi_control_WSTRB),
        .bvalid  (m_axi_control_BVALID),
        .bready  (m_axi_control_BREADY),
        .bresp   (m_axi_control_BRESP),
        .done_c  (wr_done_c),
        .resp_c  (wr_resp_c)
    );

    // Launcher sequencing, poll channel and response registers.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state                 <= IDLE;
            cmd_ready             <= 1'b1;
            busy                  <= 1'b0;
            rsp_valid             <= 1'b0;
            rsp_err               <= ERR_OK;
            rsp_cycles            <= '0;
            n_hi_q                <= '0;
            cyc_cnt               <= '0;
            gap_cnt               <= '0;
            m_axi_control_ARVALID <= 1'b0;
            m_axi_control_RREADY  <= 1'b0;
        end else begin
            if (in_poll_c) cyc_cnt <= cyc_nxt_c;
            case (state)
                IDLE: if (cmd_valid) begin
                    n_hi_q    <= cmd_n[63:32];
                    cmd_ready <= 1'b0;
                    busy      <= 1'b1;
                    state     <= WR_NLO;
                end
                WR_NLO, WR_NHI, WR_START: if (wr_done_c) begin
                    if (wr_resp_c != 2'b00) begin
                        state      <= RESP;
                        rsp_valid  <= 1'b1;
                        rsp_err    <= ERR_AXI;
                        rsp_cycles <= '0;
                    end else if (state == WR_NLO) begin
                        state <= WR_NHI;
                    end else if (state == WR_NHI) begin
                        state <= WR_START;
                    end else begin
                        state                 <= POLL_AR;
                        m_axi_control_ARVALID <= 1'b1;
                        cyc_cnt               <= '0;
                    end
                end
                POLL_AR: if (ar_hs_c) begin
                    m_axi_control_ARVALID <= 1'b0;
                    m_axi_control_RREADY  <= 1'b1;
                    state                 <= POLL_R;
                end else if (to_hit_c) begin
                    m_axi_control_ARVALID <= 1'b0;
                    state                 <= RESP;
                    rsp_valid             <= 1'b1;
                    rsp_err               <= ERR_TIMEOUT;
                    rsp_cycles            <= cyc_nxt_c;
                end
                // The read in flight always completes before any timeout check.
                POLL_R: if (r_hs_c) begin
                    m_axi_control_RREADY <= 1'b0;
                    if (m_axi_control_RRESP != 2'b00) begin
                        state      <= RESP;
                        rsp_valid  <= 1'b1;
                        rsp_err    <= ERR_AXI;
                        rsp_cycles <= cyc_nxt_c;
                    end else if (m_axi_control_RDATA[DONE_BIT]) begin
                        state      <= RESP;
                        rsp_valid  <= 1'b1;
                        rsp_err    <= ERR_OK;
                        rsp_cycles <= cyc_nxt_c;
                    end else if (to_hit_c) begin
                        state      <= RESP;
                        rsp_valid  <= 1'b1;
                        rsp_err    <= ERR_TIMEOUT;
                        rsp_cycles <= cyc_nxt_c;
                    end else begin
                        state   <= POLL_WAIT;
                        gap_cnt <= '0;
                    end
                end
                POLL_WAIT: if (to_hit_c) begin
                    state      <= RESP;
                    rsp_valid  <= 1'b1;
                    rsp_err    <= ERR_TIMEOUT;
                    rsp_cycles <= cyc_nxt_c;
                end else if (gap_end_c) begin
                    state                 <= POLL_AR;
                    m_axi_control_ARVALID <= 1'b1;
                end else begin
                    gap_cnt <= gap_cnt + GAP_W'(1);
                end
                RESP: if (rsp_ready) begin
                    rsp_valid <= 1'b0;
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vadd_launcher.sv
// Directed bench for vadd_launcher with a reactive AXI-Lite slave model.
module tb_vadd_launcher;

    logic        ap_clk = 1'b0;
    logic        ap_rst_n;
    logic        cmd_valid, cmd_ready;
    logic [63:0] cmd_n;
    logic        rsp_valid, rsp_ready;
    logic [1:0]  rsp_err;
    logic [31:0] rsp_cycles;
    logic        busy;
    logic        aw_valid, aw_ready, w_valid, w_ready, b_valid, b_ready;
    logic        ar_valid, ar_ready, r_valid, r_ready;
    logic [4:0]  aw_addr, ar_addr;
    logic [31:0] w_data, r_data;
    logic [3:0]  w_strb;
    logic [1:0]  b_resp, r_resp;

    int n_tests = 0;
    int n_fail  = 0;

    // slave configuration
    int         aw_lat = 0;
    int         w_lat  = 0;
    int         done_on = 0;
    logic       err_en = 1'b0;
    logic [4:0] err_addr = 5'h00;
    logic       log_clr = 1'b0;

    // slave state
    logic        awready_q, wready_q, aw_got, w_got;
    int          aw_cnt, w_cnt;
    logic [4:0]  s_awaddr;
    logic [31:0] s_wdata;

    // observation log
    int          cyc = 0;
    int          wr_n, rd_n, aw_hs_n, w_hs_n, early_b, t_b, t_r;
    logic [4:0]  log_addr [8];
    logic [31:0] log_data [8];

    always #5 ap_clk = ~ap_clk;

    vadd_launcher #(.POLL_GAP(4), .CNT_W(32), .TIMEOUT_CYC(50)) dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_n(cmd_n),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_err(rsp_err),
        .rsp_cycles(rsp_cycles), .busy(busy),
        .m_axi_control_AWVALID(aw_valid), .m_axi_control_AWREADY(aw_ready),
        .m_axi_control_AWADDR(aw_addr),
        .m_axi_control_WVALID(w_valid), .m_axi_control_WREADY(w_ready),
        .m_axi_control_WDATA(w_data), .m_axi_control_WSTRB(w_strb),
        .m_axi_control_BVALID(b_valid), .m_axi_control_BREADY(b_ready),
        .m_axi_control_BRESP(b_resp),
        .m_axi_control_ARVALID(ar_valid), .m_axi_control_ARREADY(ar_ready),
        .m_axi_control_ARADDR(ar_addr),
        .m_axi_control_RVALID(r_valid), .m_axi_control_RREADY(r_ready),
        .m_axi_control_RDATA(r_data), .m_axi_control_RRESP(r_resp)
    );

    assign aw_ready = (aw_lat == 0) ? 1'b1 : awready_q;
    assign w_ready  = (w_lat == 0) ? 1'b1 : wready_q;
    assign ar_ready = 1'b1;

    // Slave: programmable AW/W ready latency, B after both, status read done on read #done_on.
    always @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            awready_q <= 1'b0; wready_q <= 1'b0; aw_cnt <= 0; w_cnt <= 0;
            aw_got <= 1'b0; w_got <= 1'b0; s_awaddr <= '0; s_wdata <= '0;
            b_valid <= 1'b0; b_resp <= 2'b00;
            r_valid <= 1'b0; r_data <= '0; r_resp <= 2'b00;
        end else begin
            if (aw_valid && aw_ready) begin
                s_awaddr <= aw_addr; aw_got <= 1'b1; awready_q <= 1'b0; aw_cnt <= 0;
            end else if (aw_valid && !awready_q) begin
                if (aw_cnt >= aw_lat - 1) awready_q <= 1'b1;
                else aw_cnt <= aw_cnt + 1;
            end
            if (w_valid && w_ready) begin
                s_wdata <= w_data; w_got <= 1'b1; wready_q <= 1'b0; w_cnt <= 0;
            end else if (w_valid && !wready_q) begin
                if (w_cnt >= w_lat - 1) wready_q <= 1'b1;
                else w_cnt <= w_cnt + 1;
            end
            if (b_valid && b_ready) begin
                b_valid <= 1'b0; aw_got <= 1'b0; w_got <= 1'b0;
            end else if (aw_got && w_got && !b_valid) begin
                b_valid <= 1'b1;
                b_resp  <= (err_en && s_awaddr == err_addr) ? 2'b10 : 2'b00;
            end
            if (r_valid && r_ready) r_valid <= 1'b0;
            if (ar_valid && ar_ready) begin
                r_valid <= 1'b1;
                r_data  <= (done_on != 0 && rd_n + 1 == done_on) ? 32'h2 : 32'h0;
                r_resp  <= 2'b00;
            end
        end
    end

    // Handshake log and timestamps.
    always @(posedge ap_clk) begin
        cyc <= cyc + 1;
        if (log_clr) begin
            wr_n <= 0; rd_n <= 0; aw_hs_n <= 0; w_hs_n <= 0; early_b <= 0; t_b <= 0; t_r <= 0;
        end else begin
            if (aw_valid && aw_ready) aw_hs_n <= aw_hs_n + 1;
            if (w_valid && w_ready) w_hs_n <= w_hs_n + 1;
            if (b_ready && (aw_valid || w_valid)) early_b <= early_b + 1;
            if (b_valid && b_ready) begin
                if (wr_n < 8) begin
                    log_addr[wr_n] <= s_awaddr;
                    log_data[wr_n] <= s_wdata;
                end
                wr_n <= wr_n + 1;
                if (s_awaddr == 5'h00) t_b <= cyc;
            end
            if (ar_valid && ar_ready) rd_n <= rd_n + 1;
            if (r_valid && r_ready) t_r <= cyc;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic clear_log();
        log_clr = 1'b1;
        step();
        log_clr = 1'b0;
    endtask

    task automatic send_cmd(input logic [63:0] n);
        int k = 0;
        while (cmd_ready !== 1'b1 && k < 50) begin step(); k++; end
        cmd_valid = 1'b1;
        cmd_n     = n;
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int budget, input string tag);
        int k = 0;
        while (rsp_valid !== 1'b1 && k < budget) begin step(); k++; end
        check({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd1);
    endtask

    task automatic ack_rsp(input string tag);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check({tag, "_rsp_dropped"}, 64'(rsp_valid), 64'd0);
        check({tag, "_cmd_ready_back"}, 64'(cmd_ready), 64'd1);
    endtask

    initial begin
        int k;
        int stable_bad;
        ap_rst_n  = 1'b0;
        cmd_valid = 1'b0;
        cmd_n     = '0;
        rsp_ready = 1'b0;
        log_clr   = 1'b1;
        repeat (3) step();
        check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        check("rst_valids", 64'({aw_valid, w_valid, b_ready, ar_valid, r_ready, rsp_valid, busy}), 64'd0);
        check("rst_rsp_fields", 64'({rsp_err, rsp_cycles}), 64'd0);
        ap_rst_n = 1'b1;
        step();
        log_clr = 1'b0;

        // n=5, always-ready, done on 3rd read
        done_on = 3;
        send_cmd(64'd5);
        check("t1_busy", 64'(busy), 64'd1);
        check("t1_cmd_ready_low", 64'(cmd_ready), 64'd0);
        wait_rsp(300, "t1");
        check("t1_wr_count", 64'(wr_n), 64'd3);
        check("t1_wr0", 64'({log_addr[0], log_data[0]}), {27'd0, 5'h10, 32'd5});
        check("t1_wr1", 64'({log_addr[1], log_data[1]}), {27'd0, 5'h14, 32'd0});
        check("t1_wr2", 64'({log_addr[2], log_data[2]}), {27'd0, 5'h00, 32'd1});
        check("t1_reads", 64'(rd_n), 64'd3);
        check("t1_err", 64'(rsp_err), 64'd0);
        check("t1_cycles", 64'(rsp_cycles), 64'd14);
        check("t1_cycles_meas", 64'(rsp_cycles), 64'(t_r - t_b));
        ack_rsp("t1");
        repeat (8) step();
        check("t1_no_reread", 64'(rd_n), 64'd3);

        // W ready 3 cycles ahead of AW ready on every write
        clear_log();
        aw_lat = 4; w_lat = 1; done_on = 1;
        send_cmd(64'd3);
        wait_rsp(300, "t2");
        check("t2_aw_hs", 64'(aw_hs_n), 64'd3);
        check("t2_w_hs", 64'(w_hs_n), 64'd3);
        check("t2_early_bready", 64'(early_b), 64'd0);
        check("t2_wr_count", 64'(wr_n), 64'd3);
        check("t2_err", 64'(rsp_err), 64'd0);
        check("t2_cycles", 64'(rsp_cycles), 64'd2);
        ack_rsp("t2");

        // split 64-bit n
        clear_log();
        aw_lat = 0; w_lat = 0; done_on = 1;
        send_cmd(64'h0000_0001_0000_0002);
        wait_rsp(300, "t3");
        check("t3_wr0", 64'({log_addr[0], log_data[0]}), {27'd0, 5'h10, 32'd2});
        check("t3_wr1", 64'({log_addr[1], log_data[1]}), {27'd0, 5'h14, 32'd1});
        ack_rsp("t3");

        // SLVERR on the n_hi write
        clear_log();
        err_en = 1'b1; err_addr = 5'h14;
        send_cmd(64'd9);
        wait_rsp(300, "t4");
        check("t4_wr_count", 64'(wr_n), 64'd2);
        check("t4_reads", 64'(rd_n), 64'd0);
        check("t4_err", 64'(rsp_err), 64'd1);
        check("t4_cmd_ready_low", 64'(cmd_ready), 64'd0);
        ack_rsp("t4");
        err_en = 1'b0;

        // response back-pressure with a competing command
        clear_log();
        done_on = 1;
        send_cmd(64'd7);
        wait_rsp(300, "t5");
        cmd_valid  = 1'b1;
        cmd_n      = 64'd99;
        stable_bad = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (rsp_valid !== 1'b1 || rsp_err !== 2'd0 || rsp_cycles !== 32'd2 || cmd_ready !== 1'b0)
                stable_bad++;
        end
        check("t5_rsp_stable", 64'(stable_bad), 64'd0);
        check("t5_no_new_writes", 64'(wr_n), 64'd3);
        cmd_valid = 1'b0;
        ack_rsp("t5");

        // reset while in POLL_R
        clear_log();
        done_on = 0;
        send_cmd(64'd11);
        k = 0;
        while (r_ready !== 1'b1 && k < 100) begin step(); k++; end
        check("t6_reached_poll_r", 64'(r_ready), 64'd1);
        ap_rst_n = 1'b0;
        #1;
        check("t6_async_valids", 64'({aw_valid, w_valid, b_ready, ar_valid, r_ready, rsp_valid, busy}), 64'd0);
        check("t6_async_cmd_ready", 64'(cmd_ready), 64'd1);
        step();
        ap_rst_n = 1'b1;
        step();
        check("t6_cmd_ready_after", 64'(cmd_ready), 64'd1);
        check("t6_idle_ar", 64'(ar_valid), 64'd0);

        // done never set: timeout or unbounded polling
        clear_log();
        send_cmd(64'd12);
        k = 0;
        while (ar_valid !== 1'b1 && k < 50) begin step(); k++; end
        check("t7_poll_started", 64'(ar_valid), 64'd1);
`ifdef VADD_LAUNCHER_TIMEOUT_EN
        wait_rsp(60, "t7");
        check("t7_err_timeout", 64'(rsp_err), 64'd2);
        ack_rsp("t7");
`else
        repeat (500) step();
        check("t7_still_polling", 64'(rsp_valid), 64'd0);
        check("t7_busy", 64'(busy), 64'd1);
        check("t7_many_reads", 64'(rd_n >= 80), 64'd1);
        ap_rst_n = 1'b0;
        step();
        ap_rst_n = 1'b1;
        step();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
